// File: rtl/wfid_rr_encoder.sv
// Round-robin priority encoder: 40-bit wavefront request vector -> registered 6-bit ID
// plus one-hot copy, presented under a valid/ready handshake.
module wfid_rr_encoder #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] req,
    input  logic              grant_ready,
    output logic              grant_valid,
    output logic [WFID_W-1:0] grant_wfid,
    output logic [NUM_WF-1:0] grant_onehot
);

    logic [WFID_W-1:0] ptr;
    logic [WFID_W-1:0] next_id;
    logic [WFID_W-1:0] start;
    logic [WFID_W-1:0] sel_id;
    logic [WFID_W:0]   idx;
    logic              accept;
    logic              load;
    logic              found;

    assign accept  = grant_valid && grant_ready;
    assign load    = !grant_valid || grant_ready;
    assign next_id = (grant_wfid == WFID_W'(NUM_WF - 1)) ? '0 : grant_wfid + WFID_W'(1);
    assign start   = accept ? next_id : ptr;

    // Scan the slots from start upward, wrapping at NUM_WF (not at 2**WFID_W).
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            idx = {1'b0, start} + (WFID_W + 1)'(k);
            if (idx >= (WFID_W + 1)'(NUM_WF)) begin
                idx = idx - (WFID_W + 1)'(NUM_WF);
            end
            if (!found && req[idx[WFID_W-1:0]]) begin
                found  = 1'b1;
                sel_id = idx[WFID_W-1:0];
            end
        end
    end

    // grant_wfid deliberately keeps its last value when no request is found.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_wfid   <= '0;
            grant_onehot <= '0;
        end else begin
            if (accept) begin
                ptr <= next_id;
            end
            if (load) begin
                if (found) begin
                    grant_valid  <= 1'b1;
                    grant_wfid   <= sel_id;
                    grant_onehot <= NUM_WF'(1) << sel_id;
                end else begin
                    grant_valid  <= 1'b0;
                    grant_onehot <= '0;
                end
            end
        end
    end

endmodule
